fifo_fwft_unpacker: RTL
=======================

Name: fifo_fwft_unpacker

Overview:
- Read-side consumer for the team's first-word-feed-through FIFOs (the data_out / fifo_not_empty / shift_out side of FIFO_2word_FWFT and its relatives).
- Pops one wide word from the FIFO and emits it as RATIO narrow sub-words on a valid/ready stream.
- Sits between wide command/pixel FIFOs and byte-wide consumers (RS232 debug TX, palette byte writers).
- Sustains one sub-word per clock, including back-to-back words with no bubble.

Parameters:
- IN_BITS, 32, width of a FIFO word.
- OUT_BITS, 8, width of an emitted sub-word. IN_BITS must be an integer multiple of OUT_BITS, with RATIO = IN_BITS/OUT_BITS ≥ 2.
- LSB_FIRST, 1, 1 = emit bits [OUT_BITS-1:0] first; 0 = emit the most significant slice first.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of the word held in the unpacker
- fifo_not_empty  in  1  FWFT FIFO has a valid word on fifo_data
- fifo_data  in  IN_BITS  FWFT FIFO head word
- fifo_shift_out  out  1  pop strobe to FIFO (combinational)
- out_valid  out  1  out_data holds a valid sub-word
- out_ready  in  1  downstream accepts the sub-word this cycle
- out_data  out  OUT_BITS  current sub-word
- out_last  out  1  current sub-word is the final slice of its word
- sub_index  out  $clog2(RATIO)  index of the current slice in emission order
- busy  out  1  unpacker holds a word (equals out_valid)

Behaviour:
- State: hold_reg[IN_BITS], hold_valid, idx counter.
  - Two states: EMPTY (hold_valid=0) and UNPACK (hold_valid=1).
  - The state is fully encoded by hold_valid; no separate FSM register.
- Reset (async): hold_reg=0, hold_valid=0, idx=0. While in reset:
  - out_valid=0, out_data=0, out_last=0, sub_index=0, busy=0, fifo_shift_out=0.
- accept = out_valid && out_ready.
- done = accept && idx == RATIO-1.
- load = fifo_not_empty && !flush && (!hold_valid || done).
- fifo_shift_out = load.
  - Asserted in the same cycle the FIFO word is captured.
  - Never asserted while fifo_not_empty=0.
- On load: hold_reg <= fifo_data, hold_valid <= 1, idx <= 0.
- Else on done: hold_valid <= 0, idx <= 0.
- Else on accept: idx <= idx+1.
- Latency:
  - A word visible at cycle N with the unpacker EMPTY is popped at N.
  - First sub-word is valid at N+1.
- Throughput: with out_ready held high, RATIO sub-words per word. The next word loads on the done cycle, so there is no idle cycle between words.
- out_data = slice of hold_reg selected by idx.
  - LSB_FIRST=1: slice idx.
  - LSB_FIRST=0: slice RATIO-1-idx.
  - When hold_valid=0, out_data = 0.
- out_last = hold_valid && idx == RATIO-1.
- sub_index = idx.
- Stability rule: once out_valid=1, out_data, out_last and sub_index do not change until accept, flush or reset.
- Backpressure: out_ready=0 freezes idx and hold_reg. No pop occurs even when the FIFO is non-empty.
- Empty FIFO at done: the unpacker goes to EMPTY and out_valid drops the next cycle.
- flush:
  - Highest priority after reset.
  - Next cycle hold_valid=0 and idx=0.
  - fifo_shift_out=0 during the flush cycle, even if done would fire.
  - A sub-word accepted in the flush cycle counts as consumed; the remaining slices are discarded.
- Reset mid-word discards the held word. The FIFO is not popped again.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package gpu_stream_pkg:
  - RATIO and IDX_W computation functions, shared with future packers.
  - Elaboration-time check that IN_BITS % OUT_BITS == 0 and RATIO ≥ 2; fatal otherwise.
- No sub-module. The slice mux is an indexed part-select inside the block.
- The bench instantiates FIFO_2word_FWFT (bits=IN_BITS) upstream as a real source.

Test Plan:
- Single word, LSB_FIRST=1, out_ready=1: push 0xA1B2C3D4 → out_data D4, C3, B2, A1 on consecutive cycles, out_last only on A1, exactly one fifo_shift_out pulse.
- LSB_FIRST=0, same word → A1, B2, C3, D4; sub_index 0,1,2,3.
- Back-to-back: push 0x03020100 and 0x07060504, out_ready=1 → 00..07 in 8 consecutive cycles with out_valid continuously high; second pop coincides with the out_last of 03.
- Backpressure: 0x11223344, out_ready low on cycles 2–4 → out_data holds 33 stable through the stall; no pop while stalled with the FIFO non-empty; final sequence 44, 33, 22, 11.
- Flush after two accepts of 0xDEADBEEF (EF, BE accepted) → out_valid=0 next cycle; the next word 0x55667788 emits 88 first with sub_index=0.
- Async reset mid-word, then a FIFO empty at done → all outputs 0 during reset; out_valid drops right after out_last; fifo_shift_out never asserts with fifo_not_empty=0.

Source files
------------

// File: rtl/gpu_stream_pkg.sv
// Shared helpers for stream packers and unpackers: the word/sub-word ratio,
// the width of the slice index, and a legality check for the widths.
package gpu_stream_pkg;

   function automatic int unsigned stream_ratio(input int unsigned in_bits,
                                                input int unsigned out_bits);
      return (out_bits == 0) ? 0 : in_bits / out_bits;
   endfunction

   function automatic int unsigned stream_idx_w(input int unsigned ratio);
      return (ratio < 2) ? 1 : $clog2(ratio);
   endfunction

   function automatic bit stream_cfg_ok(input int unsigned in_bits,
                                        input int unsigned out_bits);
      return (out_bits != 0) && (in_bits % out_bits == 0) && (in_bits / out_bits >= 2);
   endfunction

endpackage

// File: rtl/FIFO_2word_FWFT.sv
// Two-entry first-word-feed-through FIFO: the head word is visible on data_out
// whenever fifo_not_empty is high and is removed by shift_out.
module FIFO_2word_FWFT #(
   parameter int unsigned bits = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            shift_in,
   input  logic [bits-1:0] data_in,
   input  logic            shift_out,
   output logic [bits-1:0] data_out,
   output logic            fifo_not_empty,
   output logic            fifo_full
);

   logic [bits-1:0] mem_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic            push;
   logic            pop;

   // A push while full is dropped even if a pop happens in the same cycle.
   assign push = shift_in  && (count_q != 2'd2);
   assign pop  = shift_out && (count_q != 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= data_in;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

   assign data_out       = mem_q[rd_ptr_q];
   assign fifo_not_empty = (count_q != 2'd0);
   assign fifo_full      = (count_q == 2'd2);

endmodule

// File: rtl/fifo_fwft_unpacker.sv
// Pops wide words from an FWFT FIFO and emits them as RATIO narrow sub-words
// on a valid/ready stream, one per clock with no bubble between words.
module fifo_fwft_unpacker
   import gpu_stream_pkg::*;
#(
   parameter int unsigned IN_BITS   = 32,
   parameter int unsigned OUT_BITS  = 8,
   parameter bit          LSB_FIRST = 1'b1,
   localparam int unsigned RATIO    = stream_ratio(IN_BITS, OUT_BITS),
   localparam int unsigned IDX_W    = stream_idx_w(RATIO)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                fifo_not_empty,
   input  logic [IN_BITS-1:0]  fifo_data,
   output logic                fifo_shift_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_BITS-1:0] out_data,
   output logic                out_last,
   output logic [IDX_W-1:0]    sub_index,
   output logic                busy
);

   if (!stream_cfg_ok(IN_BITS, OUT_BITS)) begin : g_cfg_err
      $fatal(1, "fifo_fwft_unpacker: IN_BITS must be a multiple of OUT_BITS with ratio >= 2");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic [IN_BITS-1:0] hold_q, hold_d;
   logic               hold_valid_q, hold_valid_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   slice_sel;
   logic               accept;
   logic               done;
   logic               load;

   assign accept = hold_valid_q && out_ready;
   assign done   = accept && (idx_q == LAST_IDX);
   // Gated by reset so the FIFO never sees a pop while the unpacker is held in reset.
   assign load   = !reset && fifo_not_empty && !flush && (!hold_valid_q || done);

   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      idx_d        = idx_q;
      if (flush) begin
         hold_valid_d = 1'b0;
         idx_d        = '0;
      end else if (load) begin
         hold_d       = fifo_data;
         hold_valid_d = 1'b1;
         idx_d        = '0;
      end else if (done) begin
         hold_valid_d = 1'b0;
         idx_d        = '0;
      end else if (accept) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         idx_q        <= '0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         idx_q        <= idx_d;
      end
   end

   assign slice_sel      = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
   assign out_data       = hold_valid_q ? hold_q[slice_sel*OUT_BITS +: OUT_BITS] : '0;
   assign out_valid      = hold_valid_q;
   assign out_last       = hold_valid_q && (idx_q == LAST_IDX);
   assign sub_index      = idx_q;
   assign busy           = hold_valid_q;
   assign fifo_shift_out = load;

endmodule
